// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//   Instruction-fetch stage plus the IF/ID pipeline register of the 5-stage
//   RISC-V pipeline. This stage owns the PC, selects the next PC and holds
//   the PC and IF/ID register during a load-use stall. A branch resolved in
//   MEM redirects the PC and turns the IF/ID entry into a bubble. The stage
//   also keeps fetch and stall counters. Instruction memory is external and
//   is read combinationally.
//
// Parameters
//   RESET_PC   PC loaded on reset
//   NOP_INSTR  bubble word written into IF/ID on flush (addi x0,x0,0)
//   CNT_W      width of fetch_count / stall_count
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   stall             hold PC and IF/ID (load-use hazard)
//   Branch_2          EX/MEM taken branch; branch_target is the redirect address
//   imem_addr         byte address to instruction memory (= PC_Out)
//   imem_rdata        instruction at imem_addr, same cycle
//   PC_Out / PC_In    current PC / next PC selected this cycle
//   Instruction       raw fetched word (= imem_rdata)
//   IFID_*            registered instruction, PC and valid flag for decode
//   flush_idex        squash ID/EX this cycle (= Branch_2)
//   misalign_err      sticky flag, set when a redirect target is misaligned
//   fetch_count       count of valid loads into IF/ID
//   stall_count       count of stalled (non-flush) cycles
// ---------------------------------------------------------------------------
module if_fetch_stage #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             Branch_2,
    input  logic [63:0]      branch_target,
    output logic [63:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [63:0]      PC_Out,
    output logic [63:0]      PC_In,
    output logic [31:0]      Instruction,
    output logic [31:0]      IFID_Instruction,
    output logic [63:0]      IFID_PC_Out,
    output logic             IFID_valid,
    output logic             flush_idex,
    output logic             misalign_err,
    output logic [CNT_W-1:0] fetch_count,
    output logic [CNT_W-1:0] stall_count
);

    logic [63:0]      pc_q, pc_d;
    logic [31:0]      ifid_instr_q, ifid_instr_d;
    logic [63:0]      ifid_pc_q, ifid_pc_d;
    logic             ifid_valid_q, ifid_valid_d;
    logic             misalign_q, misalign_d;
    logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // A redirect has priority over a stall. The next PC depends only on
    // the PC, stall and branch inputs. It never depends on imem_rdata.
    always_comb begin
        pc_d         = pc_q + 64'd4;
        ifid_instr_d = imem_rdata;
        ifid_pc_d    = pc_q;
        ifid_valid_d = 1'b1;
        misalign_d   = misalign_q;
        fetch_cnt_d  = fetch_cnt_q + CNT_W'(1);
        stall_cnt_d  = stall_cnt_q;

        if (Branch_2) begin
            pc_d         = {branch_target[63:2], 2'b00};
            ifid_instr_d = NOP_INSTR;
            ifid_pc_d    = '0;
            ifid_valid_d = 1'b0;
            fetch_cnt_d  = fetch_cnt_q;
            if (branch_target[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
        end else if (stall) begin
            pc_d         = pc_q;
            ifid_instr_d = ifid_instr_q;
            ifid_pc_d    = ifid_pc_q;
            ifid_valid_d = ifid_valid_q;
            fetch_cnt_d  = fetch_cnt_q;
            stall_cnt_d  = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc_q    <= '0;
            ifid_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
            fetch_cnt_q  <= '0;
            stall_cnt_q  <= '0;
        end else begin
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_valid_q <= ifid_valid_d;
            misalign_q   <= misalign_d;
            fetch_cnt_q  <= fetch_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign PC_Out           = pc_q;
    assign imem_addr        = pc_q;
    assign PC_In            = pc_d;
    assign Instruction      = imem_rdata;
    assign IFID_Instruction = ifid_instr_q;
    assign IFID_PC_Out      = ifid_pc_q;
    assign IFID_valid       = ifid_valid_q;
    assign flush_idex       = Branch_2;
    assign misalign_err     = misalign_q;
    assign fetch_count      = fetch_cnt_q;
    assign stall_count      = stall_cnt_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset, stall, Branch_2;
    logic [63:0] branch_target;

    // Two instances: default reset PC, and a reset PC near the top of the address space.
    logic [63:0] a_imem_addr, a_PC_Out, a_PC_In, a_IFID_PC_Out;
    logic [31:0] a_imem_rdata, a_Instruction, a_IFID_Instruction;
    logic        a_IFID_valid, a_flush_idex, a_misalign_err;
    logic [31:0] a_fetch_count, a_stall_count;

    logic [63:0] b_imem_addr, b_PC_Out, b_PC_In, b_IFID_PC_Out;
    logic [31:0] b_imem_rdata, b_Instruction, b_IFID_Instruction;
    logic        b_IFID_valid, b_flush_idex, b_misalign_err;
    logic [31:0] b_fetch_count, b_stall_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h9E37_79B9;
    endfunction

    assign a_imem_rdata = imem_word(a_imem_addr);
    assign b_imem_rdata = imem_word(b_imem_addr);

    if_fetch_stage #(.RESET_PC(64'h0), .NOP_INSTR(32'h0000_0013), .CNT_W(32)) u_a (
        .clk(clk), .reset(reset), .stall(stall), .Branch_2(Branch_2),
        .branch_target(branch_target), .imem_addr(a_imem_addr), .imem_rdata(a_imem_rdata),
        .PC_Out(a_PC_Out), .PC_In(a_PC_In), .Instruction(a_Instruction),
        .IFID_Instruction(a_IFID_Instruction), .IFID_PC_Out(a_IFID_PC_Out),
        .IFID_valid(a_IFID_valid), .flush_idex(a_flush_idex), .misalign_err(a_misalign_err),
        .fetch_count(a_fetch_count), .stall_count(a_stall_count)
    );

    if_fetch_stage #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFF8), .NOP_INSTR(32'h0000_0013), .CNT_W(32)) u_b (
        .clk(clk), .reset(reset), .stall(stall), .Branch_2(Branch_2),
        .branch_target(branch_target), .imem_addr(b_imem_addr), .imem_rdata(b_imem_rdata),
        .PC_Out(b_PC_Out), .PC_In(b_PC_In), .Instruction(b_Instruction),
        .IFID_Instruction(b_IFID_Instruction), .IFID_PC_Out(b_IFID_PC_Out),
        .IFID_valid(b_IFID_valid), .flush_idex(b_flush_idex), .misalign_err(b_misalign_err),
        .fetch_count(b_fetch_count), .stall_count(b_stall_count)
    );

    // Reference state: what the stage should hold after each edge.
    typedef struct {
        logic [63:0] pc;
        logic [31:0] ins;
        logic [63:0] ipc;
        logic        v;
        logic        err;
        int unsigned fc;
        int unsigned sc;
    } model_t;

    model_t ma, mb;
    bit     known = 0;

    function automatic logic [63:0] next_pc(input model_t m, input bit st, input bit br,
                                            input logic [63:0] tgt);
        if (br)      return tgt & ~64'h3;
        else if (st) return m.pc;
        else         return m.pc + 64'd4;
    endfunction

    function automatic model_t step_model(input model_t m, input bit rst, input bit st,
                                          input bit br, input logic [63:0] tgt,
                                          input logic [63:0] rpc);
        model_t n = m;
        if (rst) begin
            n.pc = rpc; n.ins = 32'h0000_0013; n.ipc = 0; n.v = 0;
            n.err = 0; n.fc = 0; n.sc = 0;
        end else begin
            n.pc = next_pc(m, st, br, tgt);
            if (br) begin
                n.ins = 32'h0000_0013; n.ipc = 0; n.v = 0;
                if (tgt % 4 != 0) n.err = 1;
            end else if (st) begin
                n.sc = m.sc + 1;
            end else begin
                n.ins = imem_word(m.pc); n.ipc = m.pc; n.v = 1; n.fc = m.fc + 1;
            end
        end
        return n;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_regs;
        check("a.PC_Out",     a_PC_Out, ma.pc);
        check("a.IFID_Instr", {32'h0, a_IFID_Instruction}, {32'h0, ma.ins});
        check("a.IFID_PC",    a_IFID_PC_Out, ma.ipc);
        check("a.IFID_valid", {63'h0, a_IFID_valid}, {63'h0, ma.v});
        check("a.misalign",   {63'h0, a_misalign_err}, {63'h0, ma.err});
        check("a.fetch_cnt",  {32'h0, a_fetch_count}, {32'h0, ma.fc});
        check("a.stall_cnt",  {32'h0, a_stall_count}, {32'h0, ma.sc});
        check("b.PC_Out",     b_PC_Out, mb.pc);
        check("b.IFID_Instr", {32'h0, b_IFID_Instruction}, {32'h0, mb.ins});
        check("b.IFID_PC",    b_IFID_PC_Out, mb.ipc);
        check("b.IFID_valid", {63'h0, b_IFID_valid}, {63'h0, mb.v});
        check("b.fetch_cnt",  {32'h0, b_fetch_count}, {32'h0, mb.fc});
        check("b.stall_cnt",  {32'h0, b_stall_count}, {32'h0, mb.sc});
    endtask

    // Apply one cycle of inputs, check combinational outputs before the edge and
    // registered outputs just after it.
    task automatic cycle(input bit rst, input bit st, input bit br, input logic [63:0] tgt);
        reset = rst; stall = st; Branch_2 = br; branch_target = tgt;
        #2;
        if (known) begin
            check("a.PC_In",       a_PC_In, next_pc(ma, st, br, tgt));
            check("b.PC_In",       b_PC_In, next_pc(mb, st, br, tgt));
            check("a.imem_addr",   a_imem_addr, ma.pc);
            check("a.Instruction", {32'h0, a_Instruction}, {32'h0, imem_word(ma.pc)});
            check("a.flush_idex",  {63'h0, a_flush_idex}, {63'h0, br});
        end
        @(posedge clk);
        ma = step_model(ma, rst, st, br, tgt, 64'h0);
        mb = step_model(mb, rst, st, br, tgt, 64'hFFFF_FFFF_FFFF_FFF8);
        if (rst) known = 1;
        #1;
        if (known) check_regs();
    endtask

    initial begin
        reset = 1; stall = 0; Branch_2 = 0; branch_target = '0;
        @(posedge clk); #1;

        // Reset for two cycles, then normal fetch.
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        check("rst.PC_Out", a_PC_Out, 64'h0);
        check("rst.IFID_Instr", {32'h0, a_IFID_Instruction}, 64'h13);
        check("rst.b.PC_Out", b_PC_Out, 64'hFFFF_FFFF_FFFF_FFF8);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        check("wrap.b.PC_Out", b_PC_Out, 64'h0);
        check("seq.a.PC_Out", a_PC_Out, 64'h8);
        // Stall for two cycles at PC 8.
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
        check("stall.PC_Out", a_PC_Out, 64'h8);
        check("stall.IFID_PC", a_IFID_PC_Out, 64'h4);
        check("stall.count", {32'h0, a_stall_count}, 64'd2);
        cycle(0, 0, 0, 0);
        check("release.PC_Out", a_PC_Out, 64'hC);
        cycle(0, 0, 0, 0);
        // Branch at PC 0x10 to 0x40.
        cycle(0, 0, 1, 64'h40);
        check("br.IFID_valid", {63'h0, a_IFID_valid}, 64'h0);
        check("br.PC_Out", a_PC_Out, 64'h40);
        cycle(0, 0, 0, 0);
        check("br.IFID_PC", a_IFID_PC_Out, 64'h40);
        // Stall and branch together: the branch wins.
        cycle(0, 1, 1, 64'h80);
        check("stbr.PC_Out", a_PC_Out, 64'h80);
        // Misaligned redirect.
        cycle(0, 0, 1, 64'h46);
        check("mis.PC_Out", a_PC_Out, 64'h44);
        check("mis.err", {63'h0, a_misalign_err}, 64'h1);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        // Reset during a stall.
        cycle(0, 1, 0, 0);
        cycle(1, 1, 0, 0);
        check("rststall.err", {63'h0, a_misalign_err}, 64'h0);
        cycle(0, 0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            bit r, s, b;
            logic [63:0] t;
            r = ($urandom_range(0, 99) < 3);
            s = ($urandom_range(0, 99) < 25);
            b = ($urandom_range(0, 99) < 12);
            t = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) t = {32'hFFFF_FFFF, 28'hFFF_FFFF, t[3:0]};
            else if ($urandom_range(0, 1) == 0) t = {48'h0, t[15:0]};
            cycle(r, s, b, t);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
